// File: rtl/aes_encrypt_iter_if.sv
// Block/cipher handshake bundle for the iterative AES core.
// The source/sink side uses master; the core uses slave.
interface aes_encrypt_iter_if #(parameter int KEY_BITS = 128);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        plain_text;
  logic [KEY_BITS-1:0] key;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        cipher;

  modport master (output in_valid, plain_text, key, out_ready,
                  input  in_ready, out_valid, cipher);
  modport slave  (input  in_valid, plain_text, key, out_ready,
                  output in_ready, out_valid, cipher);
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/256 encryptor: one round per clock, on-the-fly key expansion.
// Optional per-round trace ports when AES_ROUND_TRACE_EN is defined.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sub(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign s = sub(a);
endmodule

module aes_shift_rows (
  input  logic [127:0] d,
  output logic [127:0] q
);
  // Byte (row r, col c) sits at index 4c+r; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign q[127-8*(4*c+r) -: 8] = d[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module aes_mix_columns (
  input  logic [127:0] d,
  output logic [127:0] q
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] b0, b1, b2, b3;
    assign b0 = d[127-32*c -: 8];
    assign b1 = d[119-32*c -: 8];
    assign b2 = d[111-32*c -: 8];
    assign b3 = d[103-32*c -: 8];
    assign q[127-32*c -: 8] = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
    assign q[119-32*c -: 8] = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
    assign q[111-32*c -: 8] = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
    assign q[103-32*c -: 8] = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
  end
endmodule

module aes_encrypt_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic clk,
  input  logic rst,
  aes_encrypt_iter_if.slave bus,
  output logic busy
`ifdef AES_ROUND_TRACE_EN
  ,
  output logic         round_strobe,
  output logic [3:0]   round_idx,
  output logic [127:0] round_state
`endif
);
  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_encrypt_iter: KEY_BITS must be 128 or 256");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                fsm;
  logic [3:0]          round_q;
  logic [127:0]        st_q, sb, sr, mc, rk, st_nxt, cipher_q;
  logic [KEY_BITS-1:0] kreg, kreg_nxt;
  logic [7:0]          rcon;
  logic                rcon_adv, in_ready_q, out_valid_q;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Round datapath
  for (genvar g = 0; g < 16; g++) begin : g_sub
    aes_sbox u_sbox (.a(st_q[127-8*g -: 8]), .s(sb[127-8*g -: 8]));
  end
  aes_shift_rows  u_sr (.d(sb), .q(sr));
  aes_mix_columns u_mc (.d(sr), .q(mc));
  assign st_nxt = ((round_q == NR) ? sr : mc) ^ rk;

  // Key expansion: first four words of the next schedule chunk
  logic [31:0] w0, w1, w2, w3, wl, rot, sw, n0, n1, n2, n3;
  assign w0  = kreg[KEY_BITS-1  -: 32];
  assign w1  = kreg[KEY_BITS-33 -: 32];
  assign w2  = kreg[KEY_BITS-65 -: 32];
  assign w3  = kreg[KEY_BITS-97 -: 32];
  assign wl  = kreg[31:0];
  assign rot = {wl[23:0], wl[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_ksub
    aes_sbox u_sbox (.a(rot[31-8*g -: 8]), .s(sw[31-8*g -: 8]));
  end
  assign n0 = w0 ^ sw ^ {rcon, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  if (KEY_BITS == 256) begin : g_k256
    // Odd rounds use words 4-7 of the window and advance it by 8 words;
    // even rounds use words 0-3 of the freshly advanced window.
    logic [31:0] u, n4, n5, n6, n7;
    for (genvar g = 0; g < 4; g++) begin : g_usub
      aes_sbox u_sbox (.a(n3[31-8*g -: 8]), .s(u[31-8*g -: 8]));
    end
    assign n4       = kreg[127:96] ^ u;
    assign n5       = kreg[95:64]  ^ n4;
    assign n6       = kreg[63:32]  ^ n5;
    assign n7       = kreg[31:0]   ^ n6;
    assign rk       = round_q[0] ? kreg[127:0] : kreg[255:128];
    assign kreg_nxt = round_q[0] ? {n0, n1, n2, n3, n4, n5, n6, n7} : kreg;
    assign rcon_adv = round_q[0];
  end else begin : g_k128
    assign rk       = {n0, n1, n2, n3};
    assign kreg_nxt = {n0, n1, n2, n3};
    assign rcon_adv = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      round_q     <= 4'd0;
      st_q        <= '0;
      kreg        <= '0;
      rcon        <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      cipher_q    <= '0;
    end else begin
      case (fsm)
        IDLE: if (bus.in_valid && in_ready_q) begin
          st_q       <= bus.plain_text ^ bus.key[KEY_BITS-1 -: 128];
          kreg       <= bus.key;
          rcon       <= 8'h01;
          round_q    <= 4'd1;
          in_ready_q <= 1'b0;
          busy       <= 1'b1;
          fsm        <= RUN;
        end
        RUN: begin
          st_q <= st_nxt;
          kreg <= kreg_nxt;
          if (rcon_adv) rcon <= xt(rcon);
          if (round_q == NR) begin
            round_q     <= 4'd0;
            cipher_q    <= st_nxt;
            out_valid_q <= 1'b1;
            fsm         <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy        <= 1'b0;
          fsm         <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cipher    = cipher_q;

`ifdef AES_ROUND_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      round_strobe <= 1'b0;
      round_idx    <= 4'd0;
      round_state  <= '0;
    end else begin
      round_strobe <= (fsm == RUN);
      if (fsm == RUN) begin
        round_idx   <= round_q;
        round_state <= st_nxt;
      end
    end
  end
`endif
endmodule
